// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse packet master: state codes,
// PS/2 command/response bytes and the movement overflow clamp.
package mouse_pkg;

   typedef enum logic [3:0] {
      ST_INIT             = 4'd0,
      ST_SEND_RESET       = 4'd1,
      ST_WAIT_SENT_RESET  = 4'd2,
      ST_WAIT_ACK_RESET   = 4'd3,
      ST_WAIT_SELFTEST    = 4'd4,
      ST_WAIT_ID          = 4'd5,
      ST_SEND_ENABLE      = 4'd6,
      ST_WAIT_SENT_ENABLE = 4'd7,
      ST_WAIT_ACK_ENABLE  = 4'd8,
      ST_WAIT_BYTE1       = 4'd9,
      ST_WAIT_BYTE2       = 4'd10,
      ST_WAIT_BYTE3       = 4'd11,
      ST_INTERRUPT        = 4'd12
   } state_e;

   localparam logic [7:0] CMD_RESET     = 8'hFF;
   localparam logic [7:0] CMD_ENABLE    = 8'hF4;
   localparam logic [7:0] RESP_ACK      = 8'hFA;
   localparam logic [7:0] RESP_SELFTEST = 8'hAA;
   localparam logic [7:0] RESP_ID       = 8'h00;

   // An overflowed axis saturates to the extreme of its sign.
   function automatic logic [7:0] clamp_delta(input logic ovf, input logic sign,
                                              input logic [7:0] raw);
      return ovf ? (sign ? 8'h80 : 8'h7F) : raw;
   endfunction

   function automatic logic is_read_state(input state_e s);
      return s inside {ST_WAIT_ACK_RESET, ST_WAIT_SELFTEST, ST_WAIT_ID,
                       ST_WAIT_ACK_ENABLE, ST_WAIT_BYTE1, ST_WAIT_BYTE2,
                       ST_WAIT_BYTE3};
   endfunction

   // WAIT_BYTE1 is deliberately absent: an idle mouse never times out.
   function automatic logic is_timed_state(input state_e s);
      return s inside {ST_WAIT_SENT_RESET, ST_WAIT_ACK_RESET, ST_WAIT_SELFTEST,
                       ST_WAIT_ID, ST_WAIT_SENT_ENABLE, ST_WAIT_ACK_ENABLE,
                       ST_WAIT_BYTE2, ST_WAIT_BYTE3};
   endfunction

endpackage

// File: rtl/mouse_timeout_counter.sv
// Loadable saturating down-counter; done once it has been loaded and has
// counted down to zero. An unloaded counter (after reset) loads itself.
module mouse_timeout_counter #(
   parameter int WIDTH = 23
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] value_i,
   input  logic             en_i,
   output logic             done_o
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             armed_q, armed_d;

   always_comb begin
      count_d = count_q;
      armed_d = armed_q;
      if (load_i || !armed_q) begin
         count_d = value_i;
         armed_d = 1'b1;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         armed_q <= 1'b0;
      end else begin
         count_q <= count_d;
         armed_q <= armed_d;
      end
   end

   assign done_o = armed_q && (count_q == '0);

endmodule

// File: rtl/mouse_packet_master.sv
// PS/2 mouse bring-up sequencer and 3-byte movement packet assembler,
// pulsing SEND_INTERRUPT once per complete, clean packet.
module mouse_packet_master
   import mouse_pkg::*;
#(
   parameter int unsigned POWERUP_CYCLES = 5_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
   input  logic       CLK,
   input  logic       RESET,
   output logic       SEND_BYTE,
   output logic [7:0] BYTE_TO_SEND,
   input  logic       BYTE_SENT,
   output logic       READ_ENABLE,
   input  logic [7:0] BYTE_READ,
   input  logic [1:0] BYTE_ERROR_CODE,
   input  logic       BYTE_READY,
   output logic [7:0] MOUSE_STATUS,
   output logic [7:0] MOUSE_DX,
   output logic [7:0] MOUSE_DY,
   output logic       SEND_INTERRUPT,
   output logic [3:0] MASTER_STATE_CODE
);

   localparam int unsigned MAX_CYCLES =
      (POWERUP_CYCLES > TIMEOUT_CYCLES) ? POWERUP_CYCLES : TIMEOUT_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);

   state_e     state_q, state_d;
   logic [7:0] b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
   logic [7:0] status_q, status_d, dx_q, dx_d, dy_q, dy_d;
   logic       int_q, int_d, send_q, send_d;
   logic [7:0] cmd_q, cmd_d;

   logic rx_valid, rx_clean, pwr_done, tmo_done, tmo;

   assign READ_ENABLE = is_read_state(state_q);
   assign rx_valid    = BYTE_READY && READ_ENABLE;
   assign rx_clean    = (BYTE_ERROR_CODE == 2'd0);
   assign tmo         = tmo_done && is_timed_state(state_q);

   // Held loaded outside INIT so every return to INIT restarts the full wait.
   mouse_timeout_counter #(.WIDTH(CW)) u_powerup (
      .clk     (CLK),
      .rst_n   (RESET),
      .load_i  (state_q != ST_INIT),
      .value_i (CW'(POWERUP_CYCLES)),
      .en_i    (1'b1),
      .done_o  (pwr_done)
   );

   mouse_timeout_counter #(.WIDTH(CW)) u_timeout (
      .clk     (CLK),
      .rst_n   (RESET),
      .load_i  ((state_d != state_q) || BYTE_READY || !is_timed_state(state_q)),
      .value_i (CW'(TIMEOUT_CYCLES)),
      .en_i    (1'b1),
      .done_o  (tmo_done)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT:            if (pwr_done) state_d = ST_SEND_RESET;
         ST_SEND_RESET:      state_d = ST_WAIT_SENT_RESET;
         ST_WAIT_SENT_RESET: begin
            if (BYTE_SENT) state_d = ST_WAIT_ACK_RESET;
            else if (tmo)  state_d = ST_INIT;
         end
         ST_WAIT_ACK_RESET: begin
            if (rx_valid)
               state_d = (rx_clean && BYTE_READ == RESP_ACK) ? ST_WAIT_SELFTEST : ST_INIT;
            else if (tmo) state_d = ST_INIT;
         end
         ST_WAIT_SELFTEST: begin
            if (rx_valid)
               state_d = (rx_clean && BYTE_READ == RESP_SELFTEST) ? ST_WAIT_ID : ST_INIT;
            else if (tmo) state_d = ST_INIT;
         end
         ST_WAIT_ID: begin
            if (rx_valid)
               state_d = (rx_clean && BYTE_READ == RESP_ID) ? ST_SEND_ENABLE : ST_INIT;
            else if (tmo) state_d = ST_INIT;
         end
         ST_SEND_ENABLE:     state_d = ST_WAIT_SENT_ENABLE;
         ST_WAIT_SENT_ENABLE: begin
            if (BYTE_SENT) state_d = ST_WAIT_ACK_ENABLE;
            else if (tmo)  state_d = ST_INIT;
         end
         ST_WAIT_ACK_ENABLE: begin
            if (rx_valid)
               state_d = (rx_clean && BYTE_READ == RESP_ACK) ? ST_WAIT_BYTE1 : ST_INIT;
            else if (tmo) state_d = ST_INIT;
         end
         ST_WAIT_BYTE1: begin
            if (rx_valid && rx_clean && BYTE_READ[3]) state_d = ST_WAIT_BYTE2;
         end
         ST_WAIT_BYTE2: begin
            if (rx_valid)  state_d = rx_clean ? ST_WAIT_BYTE3 : ST_WAIT_BYTE1;
            else if (tmo)  state_d = ST_WAIT_BYTE1;
         end
         ST_WAIT_BYTE3: begin
            if (rx_valid)  state_d = rx_clean ? ST_INTERRUPT : ST_WAIT_BYTE1;
            else if (tmo)  state_d = ST_WAIT_BYTE1;
         end
         ST_INTERRUPT:       state_d = ST_WAIT_BYTE1;
         default:            state_d = ST_INIT;
      endcase
   end

   always_comb begin
      b1_d     = b1_q;
      b2_d     = b2_q;
      b3_d     = b3_q;
      status_d = status_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      cmd_d    = cmd_q;
      int_d    = (state_q == ST_INTERRUPT);
      send_d   = (state_q == ST_SEND_RESET) || (state_q == ST_SEND_ENABLE);
      if (state_q == ST_SEND_RESET)  cmd_d = CMD_RESET;
      if (state_q == ST_SEND_ENABLE) cmd_d = CMD_ENABLE;
      if (rx_valid && rx_clean) begin
         if (state_q == ST_WAIT_BYTE1 && BYTE_READ[3]) b1_d = BYTE_READ;
         if (state_q == ST_WAIT_BYTE2)                 b2_d = BYTE_READ;
         if (state_q == ST_WAIT_BYTE3)                 b3_d = BYTE_READ;
      end
      // All three outputs commit together with the interrupt pulse.
      if (state_q == ST_INTERRUPT) begin
         status_d = b1_q;
         dx_d     = clamp_delta(b1_q[6], b1_q[4], b2_q);
         dy_d     = clamp_delta(b1_q[7], b1_q[5], b3_q);
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= ST_INIT;
         b1_q     <= 8'h00;
         b2_q     <= 8'h00;
         b3_q     <= 8'h00;
         status_q <= 8'h00;
         dx_q     <= 8'h00;
         dy_q     <= 8'h00;
         cmd_q    <= 8'h00;
         int_q    <= 1'b0;
         send_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         b1_q     <= b1_d;
         b2_q     <= b2_d;
         b3_q     <= b3_d;
         status_q <= status_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         cmd_q    <= cmd_d;
         int_q    <= int_d;
         send_q   <= send_d;
      end
   end

   assign SEND_BYTE         = send_q;
   assign BYTE_TO_SEND      = cmd_q;
   assign MOUSE_STATUS      = status_q;
   assign MOUSE_DX          = dx_q;
   assign MOUSE_DY          = dy_q;
   assign SEND_INTERRUPT    = int_q;
   assign MASTER_STATE_CODE = state_q;

endmodule

// File: tb/tb_mouse_packet_master.sv
// Bench for mouse_packet_master: directed bring-up/failure scenarios plus
// randomized packets checked against a signed-clamp movement model.
module tb_mouse_packet_master;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       SEND_BYTE;
   logic [7:0] BYTE_TO_SEND;
   logic       BYTE_SENT = 1'b0;
   logic       READ_ENABLE;
   logic [7:0] BYTE_READ = 8'h00;
   logic [1:0] BYTE_ERROR_CODE = 2'd0;
   logic       BYTE_READY = 1'b0;
   logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY;
   logic       SEND_INTERRUPT;
   logic [3:0] MASTER_STATE_CODE;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] exp_status = 8'h00, exp_dx = 8'h00, exp_dy = 8'h00;

   always #5 CLK = ~CLK;

   mouse_packet_master #(.POWERUP_CYCLES(20), .TIMEOUT_CYCLES(50)) dut (
      .CLK(CLK), .RESET(RESET), .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND),
      .BYTE_SENT(BYTE_SENT), .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ),
      .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY),
      .MOUSE_STATUS(MOUSE_STATUS), .MOUSE_DX(MOUSE_DX), .MOUSE_DY(MOUSE_DY),
      .SEND_INTERRUPT(SEND_INTERRUPT), .MASTER_STATE_CODE(MASTER_STATE_CODE)
   );

   // Movement as a 9-bit signed value, saturated to the 8-bit range on overflow.
   function automatic logic [7:0] ref_delta(input logic [7:0] st, input logic [7:0] raw,
                                            input bit is_y);
      bit ovf = is_y ? st[7] : st[6];
      bit neg = is_y ? st[5] : st[4];
      int v   = neg ? int'(raw) - 256 : int'(raw);
      if (ovf) v = neg ? -128 : 127;
      return v[7:0];
   endfunction

   task automatic send_rx(input logic [7:0] b, input logic [1:0] e);
      @(negedge CLK);
      BYTE_READ = b; BYTE_ERROR_CODE = e; BYTE_READY = 1'b1;
      @(negedge CLK);
      BYTE_READY = 1'b0; BYTE_ERROR_CODE = 2'd0;
   endtask

   task automatic pulse_sent();
      @(negedge CLK); BYTE_SENT = 1'b1;
      @(negedge CLK); BYTE_SENT = 1'b0;
   endtask

   task automatic wait_send(input int budget, output bit seen, output logic [7:0] b,
                            output int cyc);
      seen = 0; b = 8'h00; cyc = 0;
      while (cyc < budget && !seen) begin
         @(negedge CLK); cyc++;
         if (SEND_BYTE === 1'b1) begin seen = 1; b = BYTE_TO_SEND; end
      end
   endtask

   task automatic feed_packet(input logic [7:0] b1, b2, b3, output logic pre, at, post,
                              output logic [7:0] st, dx, dy);
      send_rx(b1, 2'd0); send_rx(b2, 2'd0); send_rx(b3, 2'd0);
      pre = SEND_INTERRUPT;
      @(negedge CLK);
      at = SEND_INTERRUPT; st = MOUSE_STATUS; dx = MOUSE_DX; dy = MOUSE_DY;
      @(negedge CLK);
      post = SEND_INTERRUPT;
   endtask

   // Continues from the 0xFF request pulse to streaming mode.
   task automatic finish_bringup(output bit ok);
      bit seen; logic [7:0] b; int cyc;
      pulse_sent();
      send_rx(8'hFA, 2'd0); send_rx(8'hAA, 2'd0); send_rx(8'h00, 2'd0);
      wait_send(6, seen, b, cyc);
      pulse_sent();
      send_rx(8'hFA, 2'd0);
      ok = seen && (b == 8'hF4) && (MASTER_STATE_CODE == 4'd9);
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      repeat (3) @(negedge CLK);
      vectors++; if (SEND_BYTE !== 1'b0) begin miscompares++; $display("FAIL reset_send_byte: got %b want 0", SEND_BYTE); end
      vectors++; if (BYTE_TO_SEND !== 8'h00) begin miscompares++; $display("FAIL reset_cmd: got %h want 00", BYTE_TO_SEND); end
      vectors++; if (READ_ENABLE !== 1'b0) begin miscompares++; $display("FAIL reset_read_en: got %b want 0", READ_ENABLE); end
      vectors++; if (MOUSE_STATUS !== 8'h00) begin miscompares++; $display("FAIL reset_status: got %h want 00", MOUSE_STATUS); end
      vectors++; if (MOUSE_DX !== 8'h00) begin miscompares++; $display("FAIL reset_dx: got %h want 00", MOUSE_DX); end
      vectors++; if (MOUSE_DY !== 8'h00) begin miscompares++; $display("FAIL reset_dy: got %h want 00", MOUSE_DY); end
      vectors++; if (SEND_INTERRUPT !== 1'b0) begin miscompares++; $display("FAIL reset_int: got %b want 0", SEND_INTERRUPT); end
      vectors++; if (MASTER_STATE_CODE !== 4'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", MASTER_STATE_CODE); end
      $display("reset: outputs sampled while RESET low");
      RESET = 1'b1;
   endtask

   task automatic test_bringup();
      bit seen; logic [7:0] b; int cyc;
      wait_send(40, seen, b, cyc);
      vectors++; if (!seen || cyc < 20 || cyc > 26) begin miscompares++; $display("FAIL bringup_ff_time: seen %0d after %0d cycles want about 20-26", seen, cyc); end
      vectors++; if (b !== 8'hFF) begin miscompares++; $display("FAIL bringup_ff_byte: got %h want ff", b); end
      @(negedge CLK);
      vectors++; if (SEND_BYTE !== 1'b0) begin miscompares++; $display("FAIL bringup_ff_width: got %b want 0", SEND_BYTE); end
      pulse_sent();
      vectors++; if (MASTER_STATE_CODE !== 4'd3) begin miscompares++; $display("FAIL bringup_sent: got %0d want 3", MASTER_STATE_CODE); end
      send_rx(8'hFA, 2'd0);
      vectors++; if (MASTER_STATE_CODE !== 4'd4) begin miscompares++; $display("FAIL bringup_ack: got %0d want 4", MASTER_STATE_CODE); end
      send_rx(8'hAA, 2'd0);
      vectors++; if (MASTER_STATE_CODE !== 4'd5) begin miscompares++; $display("FAIL bringup_selftest: got %0d want 5", MASTER_STATE_CODE); end
      send_rx(8'h00, 2'd0);
      wait_send(6, seen, b, cyc);
      vectors++; if (!seen || b !== 8'hF4) begin miscompares++; $display("FAIL bringup_f4: seen %0d byte %h want f4", seen, b); end
      pulse_sent();
      vectors++; if (MASTER_STATE_CODE !== 4'd8) begin miscompares++; $display("FAIL bringup_sent_en: got %0d want 8", MASTER_STATE_CODE); end
      send_rx(8'hFA, 2'd0);
      vectors++; if (MASTER_STATE_CODE !== 4'd9) begin miscompares++; $display("FAIL bringup_stream: got %0d want 9", MASTER_STATE_CODE); end
      $display("bringup: reached state %0d", MASTER_STATE_CODE);
   endtask

   task automatic test_packet(input string name, input logic [7:0] b1, b2, b3);
      logic pre, at, post; logic [7:0] st, dx, dy;
      feed_packet(b1, b2, b3, pre, at, post, st, dx, dy);
      exp_status = b1; exp_dx = ref_delta(b1, b2, 0); exp_dy = ref_delta(b1, b3, 1);
      vectors++; if (pre !== 1'b0) begin miscompares++; $display("FAIL %s_int_early: got %b want 0", name, pre); end
      vectors++; if (at !== 1'b1) begin miscompares++; $display("FAIL %s_int: got %b want 1", name, at); end
      vectors++; if (post !== 1'b0) begin miscompares++; $display("FAIL %s_int_width: got %b want 0", name, post); end
      vectors++; if (st !== exp_status) begin miscompares++; $display("FAIL %s_status: got %h want %h", name, st, exp_status); end
      vectors++; if (dx !== exp_dx) begin miscompares++; $display("FAIL %s_dx: got %h want %h", name, dx, exp_dx); end
      vectors++; if (dy !== exp_dy) begin miscompares++; $display("FAIL %s_dy: got %h want %h", name, dy, exp_dy); end
      $display("%s: %h %h %h -> status %h dx %h dy %h", name, b1, b2, b3, st, dx, dy);
   endtask

   task automatic test_resync();
      send_rx(8'h00, 2'd0);
      vectors++; if (MASTER_STATE_CODE !== 4'd9) begin miscompares++; $display("FAIL resync_state: got %0d want 9", MASTER_STATE_CODE); end
      vectors++; if (SEND_INTERRUPT !== 1'b0) begin miscompares++; $display("FAIL resync_int: got %b want 0", SEND_INTERRUPT); end
      test_packet("resync", 8'h09, 8'h01, 8'h01);
   endtask

   task automatic test_random_packets();
      for (int i = 0; i < 30; i++) begin
         logic [7:0] r1, r2, r3; logic [1:0] e1, e2, e3; bit done;
         r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
         if ($urandom_range(0, 3) != 0) r1[3] = 1'b1;
         e1 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         e2 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         e3 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         done = 0;
         repeat ($urandom_range(0, 4)) @(negedge CLK);
         send_rx(r1, e1);
         if (!r1[3] || e1 != 2'd0) begin
            vectors++; if (MASTER_STATE_CODE !== 4'd9) begin miscompares++; $display("FAIL rand%0d_drop1: got %0d want 9", i, MASTER_STATE_CODE); end
            done = 1;
         end
         if (!done) begin
            repeat ($urandom_range(0, 4)) @(negedge CLK);
            send_rx(r2, e2);
            if (e2 != 2'd0) begin
               vectors++; if (MASTER_STATE_CODE !== 4'd9) begin miscompares++; $display("FAIL rand%0d_drop2: got %0d want 9", i, MASTER_STATE_CODE); end
               done = 1;
            end
         end
         if (!done) begin
            repeat ($urandom_range(0, 4)) @(negedge CLK);
            send_rx(r3, e3);
            if (e3 != 2'd0) begin
               vectors++; if (MASTER_STATE_CODE !== 4'd9) begin miscompares++; $display("FAIL rand%0d_drop3: got %0d want 9", i, MASTER_STATE_CODE); end
            end else begin
               @(negedge CLK);
               exp_status = r1; exp_dx = ref_delta(r1, r2, 0); exp_dy = ref_delta(r1, r3, 1);
               vectors++; if (SEND_INTERRUPT !== 1'b1) begin miscompares++; $display("FAIL rand%0d_int: got %b want 1", i, SEND_INTERRUPT); end
            end
         end
         vectors++; if ({MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== {exp_status, exp_dx, exp_dy}) begin
            miscompares++; $display("FAIL rand%0d_outputs: got %h %h %h want %h %h %h", i, MOUSE_STATUS, MOUSE_DX, MOUSE_DY, exp_status, exp_dx, exp_dy);
         end
         $display("rand%0d: bytes %h/%0d %h/%0d %h/%0d -> %h %h %h", i, r1, e1, r2, e2, r3, e3, MOUSE_STATUS, MOUSE_DX, MOUSE_DY);
         repeat (2) @(negedge CLK);
      end
   endtask

   task automatic test_timeout_byte2();
      bit saw_int = 0; int cyc = 0;
      send_rx(8'h18, 2'd0);
      vectors++; if (MASTER_STATE_CODE !== 4'd10) begin miscompares++; $display("FAIL tmo_enter: got %0d want 10", MASTER_STATE_CODE); end
      while (cyc < 80 && MASTER_STATE_CODE !== 4'd9) begin
         @(negedge CLK); cyc++;
         if (SEND_INTERRUPT === 1'b1) saw_int = 1;
      end
      vectors++; if (MASTER_STATE_CODE !== 4'd9 || cyc < 48 || cyc > 55) begin miscompares++; $display("FAIL tmo_return: state %0d after %0d cycles want 9 after about 51", MASTER_STATE_CODE, cyc); end
      vectors++; if (saw_int) begin miscompares++; $display("FAIL tmo_int: got 1 want 0"); end
      vectors++; if ({MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== {exp_status, exp_dx, exp_dy}) begin
         miscompares++; $display("FAIL tmo_outputs: got %h %h %h want %h %h %h", MOUSE_STATUS, MOUSE_DX, MOUSE_DY, exp_status, exp_dx, exp_dy);
      end
      $display("timeout: back to state %0d after %0d cycles", MASTER_STATE_CODE, cyc);
   endtask

   task automatic test_bringup_fail();
      bit seen, ok; logic [7:0] b; int cyc;
      RESET = 1'b0; repeat (2) @(negedge CLK); RESET = 1'b1;
      exp_status = 8'h00; exp_dx = 8'h00; exp_dy = 8'h00;
      wait_send(40, seen, b, cyc);
      pulse_sent();
      send_rx(8'hFE, 2'd0);
      vectors++; if (MASTER_STATE_CODE !== 4'd0) begin miscompares++; $display("FAIL fail_to_init: got %0d want 0", MASTER_STATE_CODE); end
      send_rx(8'hFA, 2'd0);
      vectors++; if (MASTER_STATE_CODE !== 4'd0) begin miscompares++; $display("FAIL ignored_ready: got %0d want 0", MASTER_STATE_CODE); end
      wait_send(40, seen, b, cyc);
      vectors++; if (!seen || b !== 8'hFF || (cyc + 2) < 19 || (cyc + 2) > 25) begin miscompares++; $display("FAIL fail_retry: seen %0d byte %h after %0d cycles want ff after about 22", seen, b, cyc + 2); end
      finish_bringup(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL fail_rebringup: state %0d want 9", MASTER_STATE_CODE); end
      $display("bringup_fail: retried 0xff after %0d cycles", cyc + 2);
   endtask

   task automatic test_reset_midpacket();
      test_packet("pre_reset", 8'h29, 8'h11, 8'h22);
      send_rx(8'h08, 2'd0); send_rx(8'h33, 2'd0);
      vectors++; if (MASTER_STATE_CODE !== 4'd11) begin miscompares++; $display("FAIL mid_state: got %0d want 11", MASTER_STATE_CODE); end
      #2 RESET = 1'b0;
      #1;
      vectors++; if ({MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 24'h0) begin miscompares++; $display("FAIL mid_outputs: got %h %h %h want 00 00 00", MOUSE_STATUS, MOUSE_DX, MOUSE_DY); end
      vectors++; if (MASTER_STATE_CODE !== 4'd0 || SEND_INTERRUPT !== 1'b0 || SEND_BYTE !== 1'b0) begin miscompares++; $display("FAIL mid_state_reset: state %0d int %b send %b want 0 0 0", MASTER_STATE_CODE, SEND_INTERRUPT, SEND_BYTE); end
      $display("reset_midpacket: state %0d after asynchronous reset", MASTER_STATE_CODE);
   endtask

   initial begin
      test_reset();
      test_bringup();
      test_packet("packet", 8'h08, 8'h05, 8'hFD);
      test_packet("overflow", 8'h58, 8'h10, 8'h20);
      test_resync();
      test_random_packets();
      test_timeout_byte2();
      test_bringup_fail();
      test_reset_midpacket();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", miscompares);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mouse_packet_master.md
# mouse_packet_master

Control stage between the PS/2 byte transceiver and the mouse position calculator. Drives the PS/2 mouse bring-up sequence (reset, self-test, enable streaming), then assembles each 3-byte movement packet into status/ΔX/ΔY registers. It raises a one-cycle interrupt per valid packet, which the position calculator edge-detects.

## Interface
- `POWERUP_CYCLES`, default 5_000_000: idle cycles after reset before the first command (100 ms @ 50 MHz).
- `TIMEOUT_CYCLES`, default 5_000_000: maximum wait for any expected byte.
- `CLK`  in  1  system clock.
- `RESET`  in  1  reset, asynchronous, active-low.
- `SEND_BYTE`  out  1  one-cycle request to the transmitter.
- `BYTE_TO_SEND`  out  8  command byte; valid while `SEND_BYTE` is high.
- `BYTE_SENT`  in  1  transmitter done pulse.
- `READ_ENABLE`  out  1  receiver enable.
- `BYTE_READ`  in  8  received byte.
- `BYTE_ERROR_CODE`  in  2  received-byte error code; 0 means clean.
- `BYTE_READY`  in  1  receiver byte-valid pulse.
- `MOUSE_STATUS`  out  8  packet byte 1 (YV, XV, YS, XS, 1, 0, R, L).
- `MOUSE_DX`  out  8  packet byte 2, after overflow rule.
- `MOUSE_DY`  out  8  packet byte 3, after overflow rule.
- `SEND_INTERRUPT`  out  1  one-cycle pulse when a new packet is valid.
- `MASTER_STATE_CODE`  out  4  current state encoding (debug/LEDs).

## Operation
- States and codes:
  - INIT 0
  - SEND_RESET 1
  - WAIT_SENT_RESET 2
  - WAIT_ACK_RESET 3
  - WAIT_SELFTEST 4
  - WAIT_ID 5
  - SEND_ENABLE 6
  - WAIT_SENT_ENABLE 7
  - WAIT_ACK_ENABLE 8
  - WAIT_BYTE1 9
  - WAIT_BYTE2 10
  - WAIT_BYTE3 11
  - INTERRUPT 12
- INIT: count `POWERUP_CYCLES`, then go to SEND_RESET.
- SEND_RESET: `SEND_BYTE`=1, `BYTE_TO_SEND`=0xFF for one cycle, then WAIT_SENT_RESET.
- WAIT_SENT_RESET: on `BYTE_SENT`, go to WAIT_ACK_RESET.
- Bring-up response chain: expect 0xFA, then 0xAA, then 0x00. Each must arrive with error code 0 to advance.
- SEND_ENABLE sends 0xF4. WAIT_ACK_ENABLE expects 0xFA, then goes to WAIT_BYTE1.
- Any bring-up failure returns to INIT, with the power-up counter restarted:
  - wrong byte,
  - nonzero error code,
  - `TIMEOUT_CYCLES` expiry in any WAIT_* bring-up state.
- WAIT_BYTE1:
  - Accepted only if `BYTE_READ[3]`=1 and error code is 0; otherwise the byte is dropped and the state stays WAIT_BYTE1 (resync).
  - No timeout in this state; an idle mouse is legal.
- WAIT_BYTE2 and WAIT_BYTE3: an error byte or timeout returns to WAIT_BYTE1 and discards the partial packet. Bring-up is not repeated.
- INTERRUPT: update all three outputs and pulse `SEND_INTERRUPT`, then go to WAIT_BYTE1.
- Overflow rule: if XV=1, `MOUSE_DX` = XS ? 0x80 : 0x7F. Likewise for YV/YS on `MOUSE_DY`. `MOUSE_STATUS` passes through unmodified.
- `READ_ENABLE`=1 in states 3, 4, 5, 8, 9, 10, 11; otherwise 0.
- The timeout counter clears on every state change and on every `BYTE_READY`.

## Timing
- Reset values:
  - state INIT,
  - all outputs 0 (`MASTER_STATE_CODE`=0, `SEND_BYTE`=0, `BYTE_TO_SEND`=0x00),
  - all counters 0.
- `SEND_BYTE` is high for exactly one cycle per command, registered from the SEND_* state.
- Bytes are sampled only on cycles where `BYTE_READY`=1 and `READ_ENABLE`=1. `BYTE_READY` in any other state is ignored.
- Latency from the `BYTE_READY` of byte 3 to the `SEND_INTERRUPT` rising edge is 2 cycles:
  - the byte is captured on the ready cycle,
  - the INTERRUPT state is entered the next cycle,
  - the outputs and pulse are registered from it.
- The outputs and `SEND_INTERRUPT` change in the same cycle.
- `MOUSE_STATUS`/`DX`/`DY` hold their values until the next valid packet. They are never partially updated.
- `BYTE_SENT` and `BYTE_READY` asserted together: only the event relevant to the current state counts.
- Reset mid-packet or mid-bring-up: return immediately to INIT and clear the outputs.
- Counters saturate at their terminal value; they never wrap.

## Structure
- Shared package `mouse_pkg`:
  - state enum (4-bit, codes as listed),
  - command constants CMD_RESET=0xFF, CMD_ENABLE=0xF4,
  - response constants RESP_ACK=0xFA, RESP_SELFTEST=0xAA, RESP_ID=0x00.
- Sub-module `mouse_timeout_counter`: a loadable saturating down-counter with a clear input and a done flag. It is instantiated for both the power-up wait and the timeout.
- The FSM, packet capture registers and overflow logic live in the top module.

## Test plan
Directed tests use `POWERUP_CYCLES`=20 and `TIMEOUT_CYCLES`=50.
- Clean bring-up:
  - release reset;
  - after 20 cycles, expect a `SEND_BYTE` pulse with 0xFF;
  - respond `BYTE_SENT`, then 0xFA, 0xAA, 0x00;
  - expect `SEND_BYTE` with 0xF4;
  - respond `BYTE_SENT` and 0xFA;
  - expect `MASTER_STATE_CODE`=9.
- Packet: from state 9, feed 0x08, 0x05, 0xFD → `SEND_INTERRUPT` is one cycle wide, 2 cycles after the last `BYTE_READY`, with STATUS=0x08, DX=0x05, DY=0xFD.
- Overflow: feed 0x58 (XV=1, XS=1), 0x10, 0x20 → DX=0x80, DY=0x20, STATUS=0x58.
- Resync: in state 9, feed 0x00 (bit3=0) → no state change and no interrupt. A following 0x09, 0x01, 0x01 yields an interrupt with STATUS=0x09.
- Failures:
  - answer 0xFE instead of 0xFA during bring-up → state returns to 0 and the 0xFF command repeats 20 cycles later;
  - stall 50 cycles in WAIT_BYTE2 → state returns to 9 with no interrupt and the outputs unchanged.
- Reset mid-packet: assert `RESET` low in WAIT_BYTE3 → all outputs go to 0 asynchronously and the state code is 0.
